// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master engine.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] DEFAULT_CACHE = 4'b0011;
  localparam logic [2:0] DEFAULT_PROT  = 3'b000;

  // States in which the engine is waiting on an AXI handshake.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_REQ) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Handshake watchdog: counts cycles since the last load while enabled; sticky flag on expiry.
module axil_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // TIMEOUT of zero leaves the counter parked and the flag clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (TIMEOUT != 0) begin
      if (load) begin
        cnt <= '0;
      end else if (enable && (cnt != LIMIT)) begin
        cnt <= cnt + CW'(1);
      end
      if (!load && enable && (cnt == LIMIT - CW'(1))) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_master_engine.sv
// AXI4-Lite master: converts single-beat commands into AW/W/B or AR/R transactions
// and returns one response per command. One transaction outstanding.
module axil_master_engine
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  AXI_CACHE  = DEFAULT_CACHE,
  parameter logic [2:0]  AXI_PROT   = DEFAULT_PROT,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    err_timeout,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [3:0]              M_AXI_ARCACHE,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      aw_fin, w_fin, accept;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [3:0]                awcache_d, arcache_d;
  logic [2:0]                awprot_d, arprot_d;
  logic                      cmd_ready_d, rsp_valid_d, rsp_write_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_d;
  logic [1:0]                rsp_resp_d;

  assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
  assign aw_fin = aw_done_q || (M_AXI_AWVALID && M_AXI_AWREADY);
  assign w_fin  = w_done_q  || (M_AXI_WVALID  && M_AXI_WREADY);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;

  // State and registered outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWCACHE <= '0;
      M_AXI_AWPROT  <= '0;
      M_AXI_ARCACHE <= '0;
      M_AXI_ARPROT  <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      M_AXI_AWCACHE <= awcache_d;
      M_AXI_AWPROT  <= awprot_d;
      M_AXI_ARCACHE <= arcache_d;
      M_AXI_ARPROT  <= arprot_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_write     <= rsp_write_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (aw_fin && w_fin) state_d = ST_WR_RESP;
      ST_WR_RESP: if (M_AXI_BVALID) state_d = ST_RSP;
      ST_RD_REQ:  if (M_AXI_ARREADY) state_d = ST_RD_DATA;
      ST_RD_DATA: if (M_AXI_RVALID) state_d = ST_RSP;
      ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs, derived from the upcoming state.
  always_comb begin
    aw_done_d   = (state_q == ST_WR_REQ) && aw_fin;
    w_done_d    = (state_q == ST_WR_REQ) && w_fin;
    awvalid_d   = (state_d == ST_WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == ST_WR_REQ) && !w_done_d;
    bready_d    = (state_d == ST_WR_RESP);
    arvalid_d   = (state_d == ST_RD_REQ);
    rready_d    = (state_d == ST_RD_DATA);
    awcache_d   = awvalid_d ? AXI_CACHE : 4'b0000;
    awprot_d    = awvalid_d ? AXI_PROT  : 3'b000;
    arcache_d   = arvalid_d ? AXI_CACHE : 4'b0000;
    arprot_d    = arvalid_d ? AXI_PROT  : 3'b000;
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
    rsp_write_d = rsp_write;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if (accept) begin
      addr_d = cmd_addr;
      if (cmd_write) begin
        wdata_d = cmd_wdata;
        wstrb_d = cmd_wstrb;
      end
    end
    if ((state_q == ST_WR_RESP) && M_AXI_BVALID) begin
      rsp_write_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_resp_d  = M_AXI_BRESP;
    end
    if ((state_q == ST_RD_DATA) && M_AXI_RVALID) begin
      rsp_write_d = 1'b0;
      rsp_rdata_d = M_AXI_RDATA;
      rsp_resp_d  = M_AXI_RRESP;
    end
  end

  axil_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .load    (state_d != state_q),
    .enable  (is_wait_state(state_q)),
    .expired (err_timeout)
  );

endmodule

// File: tb/tb_axil_master_engine.sv
// Scoreboard bench for axil_master_engine (64-bit data, 16-cycle watchdog) with a configurable slave.
module tb_axil_master_engine;
  import axil_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          err_timeout;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [3:0]    AWCACHE, ARCACHE;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axil_master_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata), .rsp_resp (rsp_resp), .err_timeout (err_timeout),
    .M_AXI_AWADDR (AWADDR), .M_AXI_AWCACHE (AWCACHE), .M_AXI_AWPROT (AWPROT),
    .M_AXI_AWVALID (AWVALID), .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA (WDATA), .M_AXI_WSTRB (WSTRB), .M_AXI_WVALID (WVALID), .M_AXI_WREADY (WREADY),
    .M_AXI_BVALID (BVALID), .M_AXI_BREADY (BREADY), .M_AXI_BRESP (BRESP),
    .M_AXI_ARADDR (ARADDR), .M_AXI_ARCACHE (ARCACHE), .M_AXI_ARPROT (ARPROT),
    .M_AXI_ARVALID (ARVALID), .M_AXI_ARREADY (ARREADY),
    .M_AXI_RDATA (RDATA), .M_AXI_RRESP (RRESP), .M_AXI_RVALID (RVALID), .M_AXI_RREADY (RREADY)
  );

  typedef struct packed {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Slave configuration and state
  int            aw_delay, w_delay, ar_delay, b_delay, r_delay;
  bit            aw_never, b_never;
  logic [1:0]    bresp_cfg, rresp_cfg;
  logic [DW-1:0] rdata_cfg;
  int            b_hs_count;
  int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit            aw_pend, w_pend, ar_pend, b_fire, r_fire;

  // Slave model: acts 1 time unit after each rising edge, main thread acts at 2.
  initial begin
    {AWREADY, WREADY, ARREADY, BVALID, RVALID} = '0;
    BRESP = '0; RRESP = '0; RDATA = '0; b_hs_count = 0;
    forever begin
      @(posedge ACLK); #1;
      if (ARESET) begin
        {AWREADY, WREADY, ARREADY, BVALID, RVALID} = '0;
        {aw_pend, w_pend, ar_pend, b_fire, r_fire} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        continue;
      end
      if (b_fire) begin BVALID = 1'b0; b_fire = 1'b0; b_hs_count++; end
      if (aw_pend && w_pend && !BVALID && !b_never) begin
        if (b_cnt >= b_delay) begin
          BVALID = 1'b1; BRESP = bresp_cfg; aw_pend = 1'b0; w_pend = 1'b0; b_cnt = 0;
        end else b_cnt++;
      end
      if (BVALID && BREADY) b_fire = 1'b1;
      if (r_fire) begin RVALID = 1'b0; r_fire = 1'b0; end
      if (ar_pend && !RVALID) begin
        if (r_cnt >= r_delay) begin
          RVALID = 1'b1; RDATA = rdata_cfg; RRESP = rresp_cfg; ar_pend = 1'b0; r_cnt = 0;
        end else r_cnt++;
      end
      if (RVALID && RREADY) r_fire = 1'b1;
      if (AWVALID && !aw_never && aw_cnt >= aw_delay) begin
        AWREADY = 1'b1; aw_pend = 1'b1; aw_cnt = 0;
      end else begin
        AWREADY = 1'b0; aw_cnt = AWVALID ? aw_cnt + 1 : 0;
      end
      if (WVALID && w_cnt >= w_delay) begin
        WREADY = 1'b1; w_pend = 1'b1; w_cnt = 0;
      end else begin
        WREADY = 1'b0; w_cnt = WVALID ? w_cnt + 1 : 0;
      end
      if (ARVALID && ar_cnt >= ar_delay) begin
        ARREADY = 1'b1; ar_pend = 1'b1; ar_cnt = 0;
      end else begin
        ARREADY = 1'b0; ar_cnt = ARVALID ? ar_cnt + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK); #2;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    for (int i = 0; i < 100 && !cmd_ready; i++) tick();
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1;
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
    aw_never = 1'b0; b_never = 1'b0; bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; rdata_cfg = '0;
    tick(); tick();
    n_tests++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, err_timeout, cmd_ready} !== 8'b0000_0001
        || {AWCACHE, ARCACHE, rsp_rdata, rsp_resp, rsp_write} !== '0) begin
      n_fail++;
      $display("FAIL reset got v/r=%b cache=%h/%h rdata=%h exp cmd_ready only",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, err_timeout, cmd_ready},
               AWCACHE, ARCACHE, rsp_rdata);
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    sb.push_back('{write: 1'b1, rdata: '0, resp: RESP_OKAY});
    send(1'b1, 32'h10, 64'hDEADBEEF, 8'h0F);
    n_tests++;
    if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB, AWCACHE, AWPROT} !==
        {2'b11, 32'h10, 64'hDEADBEEF, 8'h0F, 4'b0011, 3'b000}) begin
      n_fail++;
      $display("FAIL wr_issue got aw=%b w=%b addr=%h data=%h strb=%h cache=%h exp 1 1 10 deadbeef 0f 3",
               AWVALID, WVALID, AWADDR, WDATA, WSTRB, AWCACHE);
    end
    tick();
    n_tests++;
    if ({AWVALID, WVALID, BREADY, rsp_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL wr_edge1 got aw/w/bready/rsp=%b exp 0010", {AWVALID, WVALID, BREADY, rsp_valid});
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL wr_rsp_latency got rsp_valid=%b exp 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
        n_fail++;
        $display("FAIL wr_rsp got %h exp %h", {rsp_write, rsp_rdata, rsp_resp}, e);
      end
    end
    tick();
    n_tests++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_idle got cmd_ready/rsp_valid=%b exp 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_w_late();
    int b0, rsp_cnt, aw_cyc, w_cyc;
    w_delay = 3; b0 = b_hs_count; rsp_cnt = 0; aw_cyc = -1; w_cyc = -1;
    sb.push_back('{write: 1'b1, rdata: '0, resp: RESP_OKAY});
    send(1'b1, 32'h14, 64'hCAFE_F00D_1234_5678, 8'hF0);
    for (int i = 0; i < 15; i++) begin
      if (aw_cyc >= 0 && AWVALID) begin
        n_tests++; n_fail++;
        $display("FAIL w_late_aw_drop cyc %0d got AWVALID=1 exp 0", i);
      end
      if (aw_cyc >= 0 && w_cyc < 0) begin
        n_tests++;
        if ({WVALID, WDATA, WSTRB} !== {1'b1, 64'hCAFE_F00D_1234_5678, 8'hF0}) begin
          n_fail++;
          $display("FAIL w_late_hold cyc %0d got v=%b data=%h strb=%h exp 1 cafef00d12345678 f0",
                   i, WVALID, WDATA, WSTRB);
        end
      end
      if (AWVALID && AWREADY) aw_cyc = i;
      if (WVALID && WREADY) w_cyc = i;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_tests++;
          if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
            n_fail++;
            $display("FAIL w_late_rsp got %h exp %h", {rsp_write, rsp_rdata, rsp_resp}, e);
          end
        end
      end
      tick();
    end
    n_tests++;
    if (w_cyc - aw_cyc != 3 || b_hs_count - b0 != 1 || rsp_cnt != 1) begin
      n_fail++;
      $display("FAIL w_late_counts got w-aw=%0d b=%0d rsp=%0d exp 3 1 1",
               w_cyc - aw_cyc, b_hs_count - b0, rsp_cnt);
    end
    w_delay = 0;
  endtask

  task automatic test_read();
    bit ok;
    r_delay = 5; rdata_cfg = 64'h12345678; rresp_cfg = RESP_SLVERR;
    sb.push_back('{write: 1'b0, rdata: 64'h12345678, resp: RESP_SLVERR});
    send(1'b0, 32'h20, 64'h5555, 8'hFF);
    n_tests++;
    if ({ARVALID, ARADDR, ARCACHE, ARPROT, AWVALID, WVALID} !== {1'b1, 32'h20, 4'b0011, 3'b000, 2'b00}) begin
      n_fail++;
      $display("FAIL rd_issue got arvalid=%b addr=%h cache=%h aw/w=%b%b exp 1 20 3 00",
               ARVALID, ARADDR, ARCACHE, AWVALID, WVALID);
    end
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rd_rsp_timeout got rsp_valid=%b exp 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
        n_fail++;
        $display("FAIL rd_rsp got %h exp %h", {rsp_write, rsp_rdata, rsp_resp}, e);
      end
    end
    tick();
    r_delay = 0; rresp_cfg = RESP_OKAY;
  endtask

  task automatic test_rsp_stall();
    bit ok;
    logic [DW+2:0] held;
    rsp_ready = 1'b0; bresp_cfg = RESP_SLVERR;
    sb.push_back('{write: 1'b1, rdata: '0, resp: RESP_SLVERR});
    send(1'b1, 32'h30, 64'h77, 8'h03);
    wait_rsp(ok);
    held = {rsp_write, rsp_rdata, rsp_resp};
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({rsp_valid, cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 7'b1000000 ||
          {rsp_write, rsp_rdata, rsp_resp} !== held) begin
        n_fail++;
        $display("FAIL stall cyc %0d got rsp/rdy/axi=%b fields=%h exp 1000000 %h",
                 i, {rsp_valid, cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY},
                 {rsp_write, rsp_rdata, rsp_resp}, held);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
        n_fail++;
        $display("FAIL stall_rsp got %h exp %h", {rsp_write, rsp_rdata, rsp_resp}, e);
      end
    end
    tick();
    n_tests++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL stall_release got cmd_ready/rsp_valid=%b exp 10", {cmd_ready, rsp_valid});
    end
    bresp_cfg = RESP_OKAY;
  endtask

  task automatic test_timeout();
    bit ok;
    aw_never = 1'b1;
    sb.push_back('{write: 1'b1, rdata: '0, resp: RESP_OKAY});
    send(1'b1, 32'h44, 64'h1, 8'h01);
    for (int i = 0; i < 15; i++) tick();
    n_tests++;
    if ({err_timeout, AWVALID} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_early got err/awvalid=%b exp 01", {err_timeout, AWVALID});
    end
    tick();
    n_tests++;
    if ({err_timeout, AWVALID} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_set got err/awvalid=%b exp 11", {err_timeout, AWVALID});
    end
    aw_never = 1'b0;
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL timeout_rsp_wait got rsp_valid=%b exp 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp_write, rsp_rdata, rsp_resp, err_timeout} !== {e, 1'b1}) begin
        n_fail++;
        $display("FAIL timeout_rsp got %h err=%b exp %h err=1", {rsp_write, rsp_rdata, rsp_resp},
                 err_timeout, e);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    b_never = 1'b1;
    send(1'b1, 32'h50, 64'hABCD, 8'hFF);
    for (int i = 0; i < 20 && !BREADY; i++) tick();
    n_tests++;
    if (BREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reach_wr_resp got BREADY=%b exp 1", BREADY);
    end
    ARESET = 1'b1;
    tick();
    n_tests++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, err_timeout, cmd_ready} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL mid_reset got v/r=%b exp 00000001",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, err_timeout, cmd_ready});
    end
    ARESET = 1'b0; b_never = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({rsp_valid, cmd_ready, BREADY} !== 3'b010) begin
        n_fail++;
        $display("FAIL mid_after cyc %0d got rsp/rdy/bready=%b exp 010", i, {rsp_valid, cmd_ready, BREADY});
      end
    end
  endtask

  task automatic test_back_to_back_wide();
    bit ok;
    rdata_cfg = 64'hFEDC_BA98_7654_3210; rresp_cfg = RESP_DECERR;
    sb.push_back('{write: 1'b1, rdata: '0, resp: RESP_OKAY});
    sb.push_back('{write: 1'b0, rdata: 64'hFEDC_BA98_7654_3210, resp: RESP_DECERR});
    send(1'b1, 32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF);
    n_tests++;
    if ({AWVALID, WVALID, WDATA, WSTRB} !== {2'b11, 64'h0123_4567_89AB_CDEF, 8'hFF}) begin
      n_fail++;
      $display("FAIL wide_issue got aw/w=%b%b data=%h strb=%h exp 11 0123456789abcdef ff",
               AWVALID, WVALID, WDATA, WSTRB);
    end
    wait_rsp(ok);
    if (ok && sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
        n_fail++;
        $display("FAIL wide_wr_rsp got %h exp %h", {rsp_write, rsp_rdata, rsp_resp}, e);
      end
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h48;
    tick();
    n_tests++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_ready got cmd_ready/rsp_valid=%b exp 10", {cmd_ready, rsp_valid});
    end
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({ARVALID, ARADDR} !== {1'b1, 32'h48}) begin
      n_fail++;
      $display("FAIL b2b_ar got arvalid=%b addr=%h exp 1 48", ARVALID, ARADDR);
    end
    wait_rsp(ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL wide_rd_wait got rsp_valid=%b exp 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      n_tests++;
      if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
        n_fail++;
        $display("FAIL wide_rd_rsp got %h exp %h", {rsp_write, rsp_rdata, rsp_resp}, e);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_w_late();
    test_read();
    test_rsp_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back_wide();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries left exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "simulation time limit");
  end

endmodule
